alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_seq_regfile.sv | 54 +++++
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: external ALU opcodes and sequencer FSM states.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpSll = 3'b101,
        OpSrl = 3'b110,
        OpCas = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StCasCmp,
        StCasWr
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: three operand read ports, one debug read port, two data write ports
// and a flag write to the top register that overrides any data write to the same entry.
module alu_seq_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [ADDR_W-1:0] rd3_addr,
    output logic [DATA_W-1:0] rd3_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flag_en,
    input  logic              flag_val
);

    localparam logic [ADDR_W-1:0] FlagAddr = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    assign rd1_data = regs_q[rd1_addr];
    assign rd2_data = regs_q[rd2_addr];
    assign rd3_data = regs_q[rd3_addr];
    assign dbg_data = regs_q[dbg_addr];

    // Later assignments win: the flag write is applied last.
    always_comb begin
        regs_d = regs_q;
        if (wa_en) regs_d[wa_addr] = wa_data;
        if (wb_en) regs_d[wb_addr] = wb_data;
        if (flag_en) regs_d[FlagAddr] = {{(DATA_W - 1){1'b0}}, flag_val};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences register-to-register commands through an external combinational ALU,
// including a compare-and-swap that sets a flag in the top register.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
    localparam int unsigned CMD_W   = 3 + 3 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_z,
    output logic              done,
    output logic [DATA_W-1:0] res,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    state_e            state_q;
    opcode_e           op_q;
    logic [ADDR_W-1:0] a1_q, a2_q, a3_q;
    logic              z_q;

    opcode_e           cmd_op;
    logic [ADDR_W-1:0] cmd_a1, cmd_a2, cmd_a3;
    logic [DATA_W-1:0] r1, r2, r3;
    logic              wa_en, wb_en, flag_en;
    logic [ADDR_W-1:0] wa_addr, wb_addr;
    logic [DATA_W-1:0] wa_data, wb_data;

    assign cmd_op = opcode_e'(cmd[CMD_W-1 -: 3]);
    assign cmd_a1 = cmd[3*ADDR_W-1 -: ADDR_W];
    assign cmd_a2 = cmd[2*ADDR_W-1 -: ADDR_W];
    assign cmd_a3 = cmd[ADDR_W-1:0];

    // cmd_ready is registered so it stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpAdd;
            a1_q      <= '0;
            a2_q      <= '0;
            a3_q      <= '0;
            z_q       <= 1'b0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            res       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        a1_q      <= cmd_a1;
                        a2_q      <= cmd_a2;
                        a3_q      <= cmd_a3;
                        cmd_ready <= 1'b0;
                        state_q   <= (cmd_op == OpCas) ? StCasCmp : StExec;
                    end
                end
                StExec: begin
                    res       <= alu_y;
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                StCasCmp: begin
                    z_q     <= alu_z;
                    state_q <= StCasWr;
                end
                StCasWr: begin
                    res       <= {{(DATA_W - 1){1'b0}}, z_q};
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        wa_en   = 1'b0;
        wa_addr = a3_q;
        wa_data = alu_y;
        wb_en   = 1'b0;
        wb_addr = a3_q;
        wb_data = r1;
        flag_en = 1'b0;
        alu_op  = '0;
        alu_a   = '0;
        alu_b   = '0;
        unique case (state_q)
            StExec: begin
                wa_en  = 1'b1;
                alu_op = op_q;
                alu_a  = r1;
                alu_b  = r2;
            end
            StCasCmp: begin
                alu_op = OpSub;
                alu_a  = r1;
                alu_b  = r2;
            end
            StCasWr: begin
                flag_en = 1'b1;
                if (z_q) begin
                    wa_en   = 1'b1;
                    wa_addr = a1_q;
                    wa_data = r3;
                    wb_en   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    alu_seq_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_addr (a1_q),
        .rd1_data (r1),
        .rd2_addr (a2_q),
        .rd2_data (r2),
        .rd3_addr (a3_q),
        .rd3_data (r3),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flag_en  (flag_en),
        .flag_val (z_q)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, checks vector table, CAS corner cases,
// busy handling, reset abort and random commands against a register-array reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        alu_z;
    logic        done;
    logic [31:0] res;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;

    logic        load_mode = 1'b0;
    logic [31:0] load_val  = '0;
    logic [31:0] model_r [8];
    int          n_vec  = 0;
    int          n_fail = 0;

    typedef struct {
        logic [2:0]  op;
        int          a1, a2, a3;
        logic [31:0] va, vb, exp;
    } vec_t;
    vec_t tbl [8];

    always #10 clk = ~clk;

    alu_sequencer #(.DATA_W(32), .NUM_REGS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .done      (done),
        .res       (res),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    function automatic logic [31:0] alu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // External ALU; in load mode it returns a chosen constant so registers can be preset.
    always_comb begin
        alu_y = load_mode ? load_val : alu_fn(alu_op, alu_a, alu_b);
        alu_z = (alu_y == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_cmd(input logic [2:0] op, input int a1, input int a2, input int a3,
                             output logic [31:0] r);
        logic [31:0] t;
        if (op == 3'd7) begin
            r = (model_r[a1] == model_r[a2]) ? 32'd1 : 32'd0;
            if (r == 32'd1) begin
                t = model_r[a1];
                model_r[a1] = model_r[a3];
                model_r[a3] = t;
            end
            model_r[7] = r;
        end else begin
            r = load_mode ? load_val : alu_fn(op, model_r[a1], model_r[a2]);
            model_r[a3] = r;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("%s_R%0d", tag, i), rd_data, model_r[i]);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input int a1, input int a2, input int a3,
                           input logic [31:0] exp_res, input bit use_exp);
        logic [31:0] mres;
        int lat = 0;
        @(negedge clk);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd = {op, 3'(a1), 3'(a2), 3'(a3)};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("alu_op", 32'(alu_op), (op == 3'd7) ? 32'd1 : 32'(op));
                chk("alu_a", alu_a, model_r[a1]);
                chk("alu_b", alu_b, model_r[a2]);
                rd_addr = 3'(a3);
                #1 chk("no_early_write", rd_data, model_r[a3]);
            end
            if (done) lat = c;
        end
        model_cmd(op, a1, a2, a3, mres);
        chk("latency", 32'(lat), (op == 3'd7) ? 32'd3 : 32'd2);
        chk("res", res, use_exp ? exp_res : mres);
        if (!load_mode) check_regs("regs");
    endtask

    task automatic load(input int r, input logic [31:0] v);
        load_mode = 1'b1;
        load_val  = v;
        run_cmd(3'd0, 0, 0, r, v, 1'b1);
        load_mode = 1'b0;
    endtask

    task automatic busy_test();
        logic [31:0] m1, m2;
        int dones = 0, first_done = 0;
        bit acc2 = 1'b0;
        @(negedge clk);
        cmd = {3'd0, 3'd1, 3'd2, 3'd3};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd = {3'd0, 3'd3, 3'd3, 3'd5};
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_ready", 32'(cmd_ready), 32'd0);
            if (done) begin
                dones++;
                if (dones == 1) first_done = c;
            end
            if (cmd_ready && !acc2) begin
                @(posedge clk);
                #1 cmd_valid = 1'b0;
                acc2 = 1'b1;
            end
        end
        model_cmd(3'd0, 1, 2, 3, m1);
        model_cmd(3'd0, 3, 3, 5, m2);
        chk("busy_first_done", 32'(first_done), 32'd2);
        chk("busy_done_count", 32'(dones), 32'd2);
        chk("busy_res", res, m2);
        check_regs("busy");
    endtask

    task automatic reset_mid_cas();
        load(1, 32'd9);
        load(2, 32'd9);
        @(negedge clk);
        cmd = {3'd7, 3'd1, 3'd2, 3'd4};
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) model_r[i] = '0;
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        check_regs("rst");
        @(posedge clk);
        #1 chk("rst_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 chk("rst_ready_after_edge", 32'(cmd_ready), 32'd1);
        chk("rst_no_done2", 32'(done), 32'd0);
        run_cmd(3'd0, 0, 0, 1, 32'd0, 1'b1);
    endtask

    initial begin
        tbl[0] = '{3'd0, 1, 2, 3, 32'd5,        32'd7,        32'd12};
        tbl[1] = '{3'd1, 1, 2, 3, 32'd5,        32'd7,        32'hFFFF_FFFE};
        tbl[2] = '{3'd2, 4, 5, 6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
        tbl[3] = '{3'd3, 4, 5, 6, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
        tbl[4] = '{3'd4, 0, 1, 2, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        tbl[5] = '{3'd5, 2, 3, 4, 32'd1,        32'd31,       32'h8000_0000};
        tbl[6] = '{3'd6, 2, 3, 4, 32'h8000_0000, 32'd4,        32'h0800_0000};
        tbl[7] = '{3'd0, 6, 7, 6, 32'hFFFF_FFFF, 32'd1,        32'd0};

        for (int i = 0; i < 8; i++) model_r[i] = '0;
        rst_n = 1'b0;
        cmd = '0;
        cmd_valid = 1'b0;
        rd_addr = '0;
        #3;
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_res", res, 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        check_regs("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            load(tbl[i].a1, tbl[i].va);
            load(tbl[i].a2, tbl[i].vb);
            run_cmd(tbl[i].op, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].exp, 1'b1);
        end

        // CAS success, failure, flag-over-swap priority, and a1 == a3.
        load(1, 32'd9); load(2, 32'd9); load(4, 32'h55);
        run_cmd(3'd7, 1, 2, 4, 32'd1, 1'b1);
        chk("cas_ok_R1", model_r[1], 32'h55);
        load(1, 32'd9); load(2, 32'd8);
        run_cmd(3'd7, 1, 2, 4, 32'd0, 1'b1);
        load(7, 32'h77); load(1, 32'd3); load(2, 32'd3);
        run_cmd(3'd7, 1, 2, 7, 32'd1, 1'b1);
        load(5, 32'd6); load(6, 32'd6);
        run_cmd(3'd7, 5, 6, 5, 32'd1, 1'b1);

        busy_test();

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0)
                load(int'($urandom_range(0, 7)),
                     ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom()));
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 32'd0, 1'b0);
        end

        reset_mid_cas();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
